// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for an 8-digit common-anode 7-segment display.
// Latches digit data into shadow registers on load and drives the active-low anodes with blanking and blink.
module display_scanner #(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2000,
  parameter int BLINK_DIV    = 25000000
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [5*N_DIGITS-1:0]         digit_codes,
  input  logic                          load,
  input  logic [N_DIGITS-1:0]           digit_en,
  input  logic [N_DIGITS-1:0]           blink_mask,
  output logic [4:0]                    hex_code,
  output logic [N_DIGITS-1:0]           anodes,
  output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
  output logic                          blink_phase
);

  localparam int IDX_W   = $clog2(N_DIGITS);
  localparam int REF_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [REF_W-1:0]   REF_LAST   = REF_W'(REFRESH_DIV - 1);
  localparam logic [REF_W-1:0]   BLANK_END  = REF_W'(BLANK_CYCLES);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [4:0]         DASH       = 5'b10000;

  logic [REF_W-1:0]        ref_cnt, ref_next;
  logic [BLINK_W-1:0]      blink_cnt, blink_cnt_next;
  logic [IDX_W-1:0]        idx_next;
  logic                    phase_next;
  logic [5*N_DIGITS-1:0]   sh_codes, codes_next;
  logic [N_DIGITS-1:0]     sh_en, en_next;
  logic [N_DIGITS-1:0]     sh_blink, blink_next;
  logic [4:0]              hex_next;
  logic [N_DIGITS-1:0]     an_next;

  // Outputs are derived from next-state values so the registered outputs line up with the counters.
  always_comb begin
    ref_next       = (ref_cnt == REF_LAST) ? '0 : ref_cnt + 1'b1;
    idx_next       = digit_idx;
    if (ref_cnt == REF_LAST)
      idx_next = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;

    blink_cnt_next = (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    phase_next     = (blink_cnt == BLINK_LAST) ? ~blink_phase : blink_phase;

    codes_next = load ? digit_codes : sh_codes;
    en_next    = load ? digit_en    : sh_en;
    blink_next = load ? blink_mask  : sh_blink;

    hex_next = codes_next[int'(idx_next)*5 +: 5];
    an_next  = '1;
    if (ref_next >= BLANK_END && en_next[idx_next] && !(phase_next && blink_next[idx_next]))
      an_next[idx_next] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_cnt     <= '0;
      blink_cnt   <= '0;
      digit_idx   <= '0;
      blink_phase <= 1'b0;
      sh_codes    <= {N_DIGITS{DASH}};
      sh_en       <= '1;
      sh_blink    <= '0;
      hex_code    <= DASH;
      anodes      <= '1;
    end else begin
      ref_cnt     <= ref_next;
      blink_cnt   <= blink_cnt_next;
      digit_idx   <= idx_next;
      blink_phase <= phase_next;
      sh_codes    <= codes_next;
      sh_en       <= en_next;
      sh_blink    <= blink_next;
      hex_code    <= hex_next;
      anodes      <= an_next;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner, checked against a cycle-count based reference model.
// The model derives slot, position and blink phase arithmetically from the cycles elapsed since reset.
module tb_display_scanner;

  localparam int REF   = 4;
  localparam int BLANK = 1;
  localparam int BLINK = 16;
  localparam int N     = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [39:0] digit_codes = '0;
  logic        load = 1'b0;
  logic [7:0]  digit_en = 8'hFF;
  logic [7:0]  blink_mask = 8'h00;
  logic [4:0]  hex_code;
  logic [7:0]  anodes;
  logic [2:0]  digit_idx;
  logic        blink_phase;

  display_scanner #(
    .N_DIGITS(N), .REFRESH_DIV(REF), .BLANK_CYCLES(BLANK), .BLINK_DIV(BLINK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .digit_codes(digit_codes), .load(load),
    .digit_en(digit_en), .blink_mask(blink_mask), .hex_code(hex_code),
    .anodes(anodes), .digit_idx(digit_idx), .blink_phase(blink_phase)
  );

  always #5 clk = ~clk;

  int         t;
  logic [4:0] m_code [N];
  logic [7:0] m_en, m_blink;
  logic [4:0] exp_hex;
  logic [7:0] exp_an;
  logic [2:0] exp_idx;
  logic       exp_phase;
  int         vectors = 0;
  int         miscompares = 0;

  // Advance one clock: update the model from the inputs seen at the edge, then return at the falling edge.
  task automatic step();
    logic       r, l;
    logic [39:0] c;
    logic [7:0] e, b;
    int idx, pos;
    r = reset_n; l = load; c = digit_codes; e = digit_en; b = blink_mask;
    @(posedge clk);
    if (!r) begin
      t = 0;
      for (int i = 0; i < N; i++) m_code[i] = 5'b10000;
      m_en = 8'hFF;
      m_blink = 8'h00;
    end else begin
      t++;
      if (l) begin
        for (int i = 0; i < N; i++) m_code[i] = c[5*i +: 5];
        m_en = e;
        m_blink = b;
      end
    end
    idx       = (t / REF) % N;
    pos       = t % REF;
    exp_phase = ((t / BLINK) % 2) == 1;
    exp_idx   = 3'(idx);
    exp_hex   = m_code[idx];
    exp_an    = 8'hFF;
    if (pos >= BLANK && m_en[idx] && !(exp_phase && m_blink[idx])) exp_an[idx] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase} ||
          anodes !== 8'hFF || hex_code !== 5'b10000) begin
        miscompares++;
        $display("[TB] FAIL reset t=%0d got hex=%h an=%h idx=%0d ph=%b want hex=10 an=ff idx=0 ph=0",
                 t, hex_code, anodes, digit_idx, blink_phase);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase}) begin
        miscompares++;
        $display("[TB] FAIL idle_scan t=%0d got hex=%h an=%h idx=%0d ph=%b want hex=%h an=%h idx=%0d ph=%b",
                 t, hex_code, anodes, digit_idx, blink_phase, exp_hex, exp_an, exp_idx, exp_phase);
      end
    end
  endtask

  task automatic test_load_scan();
    for (int i = 0; i < 7; i++) digit_codes[5*i +: 5] = 5'(i + 1);
    digit_codes[35 +: 5] = 5'b10001;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 36; i++) begin
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase} ||
          hex_code !== ((digit_idx == 3'd7) ? 5'b10001 : 5'(digit_idx + 3'd1))) begin
        miscompares++;
        $display("[TB] FAIL load_scan t=%0d got hex=%h an=%h idx=%0d ph=%b want hex=%h an=%h idx=%0d ph=%b",
                 t, hex_code, anodes, digit_idx, blink_phase, exp_hex, exp_an, exp_idx, exp_phase);
      end
      step();
    end
  endtask

  task automatic test_tear_free();
    int guard;
    digit_codes = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase} ||
          hex_code === 5'b00000) begin
        miscompares++;
        $display("[TB] FAIL tear_hold t=%0d got hex=%h an=%h idx=%0d want hex=%h an=%h idx=%0d",
                 t, hex_code, anodes, digit_idx, exp_hex, exp_an, exp_idx);
      end
    end
    guard = 0;
    while (t % REF != REF - 1 && guard < 2 * REF) begin
      step();
      guard++;
    end
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 12; i++) begin
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase} ||
          hex_code !== 5'b00000) begin
        miscompares++;
        $display("[TB] FAIL tear_load t=%0d got hex=%h an=%h idx=%0d want hex=%h an=%h idx=%0d",
                 t, hex_code, anodes, digit_idx, exp_hex, exp_an, exp_idx);
      end
      step();
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < N; i++) digit_codes[5*i +: 5] = 5'($urandom_range(0, 17));
    digit_en = 8'b1111_0000;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 40; i++) begin
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase} ||
          (digit_idx < 3'd4 && anodes !== 8'hFF)) begin
        miscompares++;
        $display("[TB] FAIL enable t=%0d got hex=%h an=%h idx=%0d ph=%b want hex=%h an=%h idx=%0d ph=%b",
                 t, hex_code, anodes, digit_idx, blink_phase, exp_hex, exp_an, exp_idx, exp_phase);
      end
      step();
    end
  endtask

  task automatic test_blink();
    digit_en = 8'hFF;
    blink_mask = 8'h01;
    load = 1'b1;
    step();
    load = 1'b0;
    for (int i = 0; i < 80; i++) begin
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase}) begin
        miscompares++;
        $display("[TB] FAIL blink t=%0d got an=%h idx=%0d ph=%b want an=%h idx=%0d ph=%b",
                 t, anodes, digit_idx, blink_phase, exp_an, exp_idx, exp_phase);
      end
      step();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      digit_codes = {$urandom, $urandom};
      digit_en    = 8'($urandom);
      blink_mask  = 8'($urandom);
      load        = ($urandom_range(0, 9) < 3);
      reset_n     = ($urandom_range(0, 99) != 0);
      step();
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase}) begin
        miscompares++;
        $display("[TB] FAIL random t=%0d got hex=%h an=%h idx=%0d ph=%b want hex=%h an=%h idx=%0d ph=%b",
                 t, hex_code, anodes, digit_idx, blink_phase, exp_hex, exp_an, exp_idx, exp_phase);
      end
    end
    load = 1'b0;
    reset_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    int guard;
    guard = 0;
    while (!(exp_idx == 3'd5 && t % REF == 2) && guard < 4 * REF * N) begin
      step();
      guard++;
    end
    vectors++;
    if (digit_idx !== 3'd5) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_reach got idx=%0d want idx=5", digit_idx);
    end
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    vectors++;
    if ({hex_code, anodes, digit_idx, blink_phase} !== {5'b10000, 8'hFF, 3'd0, 1'b0} ||
        {exp_hex, exp_an, exp_idx, exp_phase} !== {5'b10000, 8'hFF, 3'd0, 1'b0}) begin
      miscompares++;
      $display("[TB] FAIL reset_mid got hex=%h an=%h idx=%0d ph=%b want hex=10 an=ff idx=0 ph=0",
               hex_code, anodes, digit_idx, blink_phase);
    end
    for (int i = 0; i < 36; i++) begin
      step();
      vectors++;
      if ({hex_code, anodes, digit_idx, blink_phase} !== {exp_hex, exp_an, exp_idx, exp_phase} ||
          hex_code !== 5'b10000) begin
        miscompares++;
        $display("[TB] FAIL reset_mid_after t=%0d got hex=%h an=%h idx=%0d want hex=%h an=%h idx=%0d",
                 t, hex_code, anodes, digit_idx, exp_hex, exp_an, exp_idx);
      end
    end
  endtask

  initial begin
    t = 0;
    test_reset();
    test_load_scan();
    test_tear_free();
    test_enable();
    test_blink();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
